// File: rtl/dmem_pkg.sv
// Shared definitions for the data-side memory responder.
// Holds the MMIO register offsets, the console status bit positions, the
// region-select encoding used by the address decoder and a helper that packs
// the console status word.
package dmem_pkg;

  // MMIO register offsets within the 16-byte window
  localparam logic [3:0] CONSOLE_TX     = 4'h0;
  localparam logic [3:0] CONSOLE_STATUS = 4'h4;
  localparam logic [3:0] CYCLE_LO       = 4'h8;
  localparam logic [3:0] CYCLE_HI       = 4'hC;

  // Console status bit positions
  localparam int unsigned FULL      = 0;
  localparam int unsigned EMPTY     = 1;
  localparam int unsigned OVF       = 2;
  localparam int unsigned COUNT_LSB = 8;

  typedef enum logic [1:0] {
    SEL_RAM,
    SEL_MMIO,
    SEL_NONE
  } sel_e;

  function automatic logic [31:0] pack_status(input logic       full,
                                              input logic       empty,
                                              input logic       ovf,
                                              input logic [7:0] count);
    logic [31:0] s;
    s                   = '0;
    s[FULL]             = full;
    s[EMPTY]            = empty;
    s[OVF]              = ovf;
    s[COUNT_LSB +: 8]   = count;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head view.
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   push, push_data    write request; accepted when not full, or when full
//                      and a pop happens in the same cycle
//   pop                read request; ignored while empty
//   head               entry at the head, zero while empty
//   full, empty, count occupancy (count ranges 0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW + 1)'(DEPTH));
  assign count   = count_q;
  assign do_pop  = pop & ~empty;
  // A pop frees the slot the push needs, so push-when-full is fine then
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  // Storage has no reset; the pointers decide what is valid
  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory end of the single-cycle core's data port: word RAM plus an MMIO
// window holding a console TX FIFO, its status register and a 64-bit cycle
// counter. Loads are combinational; stores commit on the clock edge.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   data_addr, write_data, mem_write core data request (byte address)
//   read_data                       combinational load data
//   console_data/valid/ready        console byte stream (valid/ready)
//   access_fault                    sticky bad-store flag, only present when
//                                   DMEM_ACCESS_FAULT_EN is defined
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_addr,
  input  logic [31:0] write_data,
  input  logic        mem_write,
  output logic [31:0] read_data,
  output logic [7:0]  console_data,
  output logic        console_valid,
  input  logic        console_ready
`ifdef DMEM_ACCESS_FAULT_EN
  ,
  output logic        access_fault
`endif
);

  localparam int unsigned RAM_AW    = $clog2(RAM_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

  // Address decode; byte offset bits are ignored
  sel_e              sel;
  logic [3:0]        mmio_off;
  logic [RAM_AW-1:0] ram_idx;

  always_comb begin
    sel = SEL_NONE;
    if ({1'b0, data_addr} < RAM_BYTES) begin
      sel = SEL_RAM;
    end else if (data_addr[31:4] == MMIO_BASE[31:4]) begin
      sel = SEL_MMIO;
    end
  end

  assign mmio_off = {data_addr[3:2], 2'b00};
  assign ram_idx  = data_addr[RAM_AW+1:2];

  // RAM has no reset, so a store coincident with reset still lands
  logic [31:0] ram_q [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (mem_write && sel == SEL_RAM) begin
      ram_q[ram_idx] <= write_data;
    end
  end

  logic [63:0] cycle_q;

  always_ff @(posedge clk) begin
    if (reset) cycle_q <= '0;
    else       cycle_q <= cycle_q + 64'd1;
  end

  // Console FIFO and sticky overflow
  logic                          tx_push, status_wr;
  logic                          fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overflow_q;

  assign tx_push   = mem_write & (sel == SEL_MMIO) & (mmio_off == CONSOLE_TX);
  assign status_wr = mem_write & (sel == SEL_MMIO) & (mmio_off == CONSOLE_STATUS);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_console_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (write_data[7:0]),
    .pop       (console_ready),
    .head      (console_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign console_valid = ~fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (status_wr) begin
      overflow_q <= 1'b0;
    end else if (tx_push && fifo_full && !console_ready) begin
      // Full with no pop this edge: the byte is dropped
      overflow_q <= 1'b1;
    end
  end

  // Load path: no side effects, purely a function of address and state
  always_comb begin
    read_data = '0;
    unique case (sel)
      SEL_RAM: read_data = ram_q[ram_idx];
      SEL_MMIO: begin
        case (mmio_off)
          CONSOLE_STATUS: read_data = pack_status(fifo_full, fifo_empty, overflow_q,
                                                  8'(fifo_count));
          CYCLE_LO:       read_data = cycle_q[31:0];
          CYCLE_HI:       read_data = cycle_q[63:32];
          default:        read_data = '0;
        endcase
      end
      default: read_data = '0;
    endcase
  end

`ifdef DMEM_ACCESS_FAULT_EN
  logic fault_q;
  logic bad_store;

  assign bad_store = mem_write &
                     ((sel == SEL_NONE) |
                      ((sel == SEL_MMIO) & ((mmio_off == CYCLE_LO) | (mmio_off == CYCLE_HI))) |
                      (data_addr[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (reset)          fault_q <= 1'b0;
    else if (bad_store) fault_q <= 1'b1;
  end

  assign access_fault = fault_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios followed by random traffic,
// all checked against a behavioural model (word map, byte queue, counters).
module tb_dmem_responder;

  localparam int unsigned RAM_WORDS  = 1024;
  localparam logic [31:0] MMIO_BASE  = 32'h1000_0000;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam logic [31:0] RAM_BYTES  = RAM_WORDS * 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_addr = '0;
  logic [31:0] write_data = '0;
  logic        mem_write = 1'b0;
  logic [31:0] read_data;
  logic [7:0]  console_data;
  logic        console_valid;
  logic        console_ready = 1'b0;
`ifdef DMEM_ACCESS_FAULT_EN
  logic        access_fault;
`endif

  always #5 clk = ~clk;

  dmem_responder #(
    .RAM_WORDS  (RAM_WORDS),
    .MMIO_BASE  (MMIO_BASE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data_addr     (data_addr),
    .write_data    (write_data),
    .mem_write     (mem_write),
    .read_data     (read_data),
    .console_data  (console_data),
    .console_valid (console_valid),
    .console_ready (console_ready)
`ifdef DMEM_ACCESS_FAULT_EN
    ,
    .access_fault  (access_fault)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  // Reference model state
  logic [31:0] ram_m [int];
  logic [7:0]  sb [$];
  int          m_count = 0;
  bit          m_ovf   = 1'b0;
  logic [63:0] m_cyc   = '0;
`ifdef DMEM_ACCESS_FAULT_EN
  bit          m_fault = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
  endtask

  // Expected load value; returns 0 when the RAM word was never written
  function automatic bit exp_read(input logic [31:0] a, output logic [31:0] v);
    v = '0;
    if (a < RAM_BYTES) begin
      if (!ram_m.exists(int'(a[31:2]))) return 1'b0;
      v = ram_m[int'(a[31:2])];
    end else if (a[31:4] == MMIO_BASE[31:4]) begin
      case (a[3:2])
        2'd1: begin
          v[15:8] = 8'(m_count);
          v[2]    = m_ovf;
          v[1]    = (m_count == 0);
          v[0]    = (m_count == FIFO_DEPTH);
        end
        2'd2:    v = m_cyc[31:0];
        2'd3:    v = m_cyc[63:32];
        default: v = '0;
      endcase
    end
    return 1'b1;
  endfunction

  // One clock cycle: drive at negedge, check the load, then update the model
  task automatic step(input logic [31:0] a, input logic [31:0] d, input bit we, input bit rdy,
                      input bit rst, output logic [31:0] rd);
    logic [31:0] ev;
    bit in_ram, in_mmio, pop_m, full_m;
    logic [1:0] off;
    @(negedge clk);
    data_addr = a; write_data = d; mem_write = we; console_ready = rdy; reset = rst;
    #1;
    rd = read_data;
    if (exp_read(a, ev)) check("read_data", rd, ev);
    in_ram  = (a < RAM_BYTES);
    in_mmio = !in_ram && (a[31:4] == MMIO_BASE[31:4]);
    off     = a[3:2];
    pop_m   = rdy && (m_count > 0);
    full_m  = (m_count == FIFO_DEPTH);
    @(posedge clk);
    #1;
    if (we && in_ram) ram_m[int'(a[31:2])] = d;
    if (rst) begin
      m_count = 0; m_ovf = 1'b0; m_cyc = '0;
      sb.delete();
`ifdef DMEM_ACCESS_FAULT_EN
      m_fault = 1'b0;
`endif
    end else begin
      m_cyc = m_cyc + 64'd1;
      if (we && in_mmio && off == 2'd0) begin
        if (!full_m || pop_m) begin
          sb.push_back(d[7:0]);
          m_count++;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (pop_m) m_count--;
      if (we && in_mmio && off == 2'd1) m_ovf = 1'b0;
`ifdef DMEM_ACCESS_FAULT_EN
      if (we && (!(in_ram || in_mmio) || (in_mmio && off >= 2'd2) || a[1:0] != 2'b00))
        m_fault = 1'b1;
`endif
    end
  endtask

  // Monitor: the byte stream is checked against the scoreboard queue
  initial begin : monitor
    forever begin
      @(negedge clk);
      #3;
      if (mon_en) begin
        check1("console_valid", console_valid, sb.size() != 0);
        if (sb.size() != 0) begin
          check("console_data", {24'h0, console_data}, {24'h0, sb[0]});
          if (console_valid && console_ready) void'(sb.pop_front());
        end else begin
          check("console_data_idle", {24'h0, console_data}, 32'h0);
        end
`ifdef DMEM_ACCESS_FAULT_EN
        check1("access_fault", access_fault, m_fault);
`endif
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] rd;
    logic [31:0] a, d;
    bit we, rdy, rst;

    // Reset held two cycles; counter reads 0 and the FIFO reads empty
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, rd);
    mon_en = 1'b1;
    step(MMIO_BASE + 32'h8, 32'h0, 1'b0, 1'b0, 1'b1, rd);
    check("cycle_lo_in_reset", rd, 32'h0);
    for (int i = 0; i < 4; i++) step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, rd);
    step(MMIO_BASE + 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, rd);
    check("status_after_reset", rd, 32'h0000_0002);
    step(MMIO_BASE + 32'h8, 32'h0, 1'b0, 1'b0, 1'b0, rd);
    check("cycle_lo_5", rd, 32'd5);
    step(MMIO_BASE + 32'hC, 32'h0, 1'b0, 1'b0, 1'b0, rd);
    check("cycle_hi_0", rd, 32'd0);

    // Carry from the low into the high counter half
    force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
    release dut.cycle_q;
    m_cyc = 64'h0000_0000_FFFF_FFFF;
    step(MMIO_BASE + 32'h8, 32'h0, 1'b0, 1'b0, 1'b0, rd);
    check("cycle_lo_max", rd, 32'hFFFF_FFFF);
    step(MMIO_BASE + 32'h8, 32'h0, 1'b0, 1'b0, 1'b0, rd);
    check("cycle_lo_wrap", rd, 32'h0);
    step(MMIO_BASE + 32'hC, 32'h0, 1'b0, 1'b0, 1'b0, rd);
    check("cycle_hi_carry", rd, 32'h1);

    // RAM store, misaligned load of the same word, neighbour untouched
    step(32'h14, 32'h1234_5678, 1'b1, 1'b0, 1'b0, rd);
    step(32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, rd);
    step(32'h13, 32'h0, 1'b0, 1'b0, 1'b0, rd);
    check("ram_misaligned_read", rd, 32'hDEAD_BEEF);
    step(32'h14, 32'h0, 1'b0, 1'b0, 1'b0, rd);
    check("ram_neighbour", rd, 32'h1234_5678);

    // Three bytes queued, then drained on consecutive cycles
    step(MMIO_BASE, 32'h41, 1'b1, 1'b0, 1'b0, rd);
    step(MMIO_BASE, 32'h42, 1'b1, 1'b0, 1'b0, rd);
    step(MMIO_BASE, 32'h43, 1'b1, 1'b0, 1'b0, rd);
    step(MMIO_BASE + 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, rd);
    check("status_three", rd, 32'h0000_0300);
    check("console_head_41", {24'h0, console_data}, 32'h41);
    for (int i = 0; i < 3; i++) step(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, rd);
    step(MMIO_BASE + 32'h4, 32'h0, 1'b0, 1'b1, 1'b0, rd);
    check("status_drained", rd, 32'h0000_0002);

    // Fill, overflow, clear, push-while-full-and-popping
    for (int i = 0; i < FIFO_DEPTH; i++) step(MMIO_BASE, 32'(i + 8'h60), 1'b1, 1'b0, 1'b0, rd);
    step(MMIO_BASE, 32'h99, 1'b1, 1'b0, 1'b0, rd);
    step(MMIO_BASE + 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, rd);
    check("status_overflow", rd, 32'h0000_1005);
    step(MMIO_BASE + 32'h4, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, rd);
    step(MMIO_BASE + 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, rd);
    check("status_ovf_cleared", rd, 32'h0000_1001);
    step(MMIO_BASE, 32'hAA, 1'b1, 1'b1, 1'b0, rd);
    step(MMIO_BASE + 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, rd);
    check("status_full_push_pop", rd, 32'h0000_1001);
    for (int i = 0; i < FIFO_DEPTH; i++) step(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, rd);

    // Reset with bytes queued; RAM keeps contents and takes a coincident store
    step(32'h20, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, rd);
    for (int i = 0; i < 4; i++) step(MMIO_BASE, 32'(8'h30 + i), 1'b1, 1'b0, 1'b0, rd);
    step(32'h24, 32'h0BAD_CAFE, 1'b1, 1'b0, 1'b1, rd);
    step(MMIO_BASE + 32'h4, 32'h0, 1'b0, 1'b1, 1'b0, rd);
    check("status_after_midreset", rd, 32'h0000_0002);
    check1("valid_after_midreset", console_valid, 1'b0);
    step(32'h20, 32'h0, 1'b0, 1'b0, 1'b0, rd);
    check("ram_survives_reset", rd, 32'hCAFE_F00D);
    step(32'h24, 32'h0, 1'b0, 1'b0, 1'b0, rd);
    check("ram_store_in_reset", rd, 32'h0BAD_CAFE);

`ifdef DMEM_ACCESS_FAULT_EN
    step(32'h2000_0000, 32'h1, 1'b1, 1'b0, 1'b0, rd);
    step(32'h2000_0000, 32'h0, 1'b0, 1'b0, 1'b0, rd);
    check("unmapped_read", rd, 32'h0);
    check1("fault_set", access_fault, 1'b1);
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, rd);
    check1("fault_sticky", access_fault, 1'b1);
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, rd);
`endif

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int unsigned kind;
      kind = $urandom_range(0, 9);
      d    = $urandom();
      if (kind <= 3) begin
        a  = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
        we = ($urandom_range(0, 99) < 40);
      end else if (kind <= 7) begin
        a  = MMIO_BASE | ($urandom_range(0, 5) > 3 ? 32'h0 : 32'($urandom_range(0, 3) << 2))
             | $urandom_range(0, 3);
        we = ($urandom_range(0, 99) < 60);
      end else if (kind == 8) begin
        a  = 32'h2000_0000 | $urandom_range(0, 255);
        we = ($urandom_range(0, 99) < 30);
      end else begin
        case ($urandom_range(0, 3))
          0:       a = RAM_BYTES - 32'd4;
          1:       a = RAM_BYTES;
          2:       a = MMIO_BASE - 32'd4;
          default: a = MMIO_BASE + 32'h10;
        endcase
        we = ($urandom_range(0, 99) < 40);
      end
      rdy = ((i % 1000) < 500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step(a, d, we, rdy, rst, rd);
    end

    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, rd);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
